// File: rtl/ctrl_pipe_pkg.sv
// Control-word layout, field encodings and bubble constant.
// The main decoder and ctrl_pipe import the same definitions.
package ctrl_pipe_pkg;

  localparam int unsigned NB_CTRL_WORD = 14;
  localparam int unsigned NB_EX_CTRL   = 11;  // b10:0, registered into EX
  localparam int unsigned NB_MEM_CTRL  = 4;   // reg_write, mem_to_reg, mem_write
  localparam int unsigned NB_WB_CTRL   = 3;   // reg_write, mem_to_reg

  localparam int unsigned CTRL_NEXT_PC_SRC_BIT = 13;
  localparam int unsigned CTRL_JMP_CTRL_LSB    = 11;
  localparam int unsigned CTRL_JMP_CTRL_W      = 2;
  localparam int unsigned CTRL_REG_WRITE_BIT   = 10;
  localparam int unsigned CTRL_REG_DST_LSB     = 8;
  localparam int unsigned CTRL_REG_DST_W       = 2;
  localparam int unsigned CTRL_MEM_TO_REG_LSB  = 6;
  localparam int unsigned CTRL_MEM_TO_REG_W    = 2;
  localparam int unsigned CTRL_MEM_WRITE_BIT   = 5;
  localparam int unsigned CTRL_ALU_SRC_LSB     = 3;
  localparam int unsigned CTRL_ALU_SRC_W       = 2;
  localparam int unsigned CTRL_ALU_OP_LSB      = 0;
  localparam int unsigned CTRL_ALU_OP_W        = 3;

  localparam logic [1:0] MEM_TO_REG_ALU  = 2'b00;
  localparam logic [1:0] MEM_TO_REG_LOAD = 2'b01;
  localparam logic [1:0] MEM_TO_REG_LINK = 2'b10;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [NB_CTRL_WORD-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// Generic pipeline stage register with hold, bubble insert and a valid bit.
// Priority: reset, hold, bubble, load.
module ctrl_stage_reg #(
  parameter int unsigned NB_DATA = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_hold,
  input  logic               i_bubble,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid
);

  logic [NB_DATA-1:0] r_data;
  logic               r_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_hold) begin
      r_data  <= r_data;
      r_valid <= r_valid;
    end else if (i_bubble) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_data  <= i_data;
      r_valid <= i_valid;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control pipeline with bubble, halt and status outputs.
// Optional statistics counters are enabled by defining CTRL_PIPE_STATS_EN.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned NB_CTRL = 14
`ifdef CTRL_PIPE_STATS_EN
  ,
  parameter int unsigned NB_STAT = 32
`endif
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_CTRL-1:0] i_ctrl_regs,
  input  logic               i_valid,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_halt,
  output logic               o_ex_reg_write,
  output logic [1:0]         o_ex_reg_dst,
  output logic [1:0]         o_ex_mem_to_reg,
  output logic               o_ex_mem_write,
  output logic [1:0]         o_ex_alu_src,
  output logic [2:0]         o_ex_alu_op,
  output logic               o_ex_mem_read,
  output logic               o_mem_reg_write,
  output logic [1:0]         o_mem_mem_to_reg,
  output logic               o_mem_mem_write,
  output logic               o_wb_reg_write,
  output logic [1:0]         o_wb_mem_to_reg,
`ifdef CTRL_PIPE_STATS_EN
  output logic [NB_STAT-1:0] o_stat_retired,
  output logic [NB_STAT-1:0] o_stat_bubbles,
  output logic [NB_STAT-1:0] o_stat_stores,
`endif
  output logic               o_pipe_empty
);

  logic [NB_EX_CTRL-1:0]  w_ex_next;
  logic [NB_EX_CTRL-1:0]  w_ex_q;
  logic [NB_MEM_CTRL-1:0] w_mem_next;
  logic [NB_MEM_CTRL-1:0] w_mem_q;
  logic [NB_WB_CTRL-1:0]  w_wb_q;
  logic                   w_ex_valid;
  logic                   w_mem_valid;
  logic                   w_wb_valid;
  logic                   w_ex_bubble;
  logic                   w_unused_id_bits;

  // next_pc_src and jmp_ctrl are consumed in ID.
  assign w_unused_id_bits = ^i_ctrl_regs[NB_CTRL-1:NB_EX_CTRL];

  // Without reg_write, reg_dst and mem_to_reg are don't-cares; store them as 0.
  always_comb begin
    w_ex_next = i_ctrl_regs[NB_EX_CTRL-1:0];
    if (!w_ex_next[CTRL_REG_WRITE_BIT]) begin
      w_ex_next[CTRL_REG_DST_LSB +: CTRL_REG_DST_W]       = '0;
      w_ex_next[CTRL_MEM_TO_REG_LSB +: CTRL_MEM_TO_REG_W] = '0;
    end
  end

  assign w_ex_bubble = i_stall | i_flush | ~i_valid;

  ctrl_stage_reg #(
    .NB_DATA (NB_EX_CTRL)
  ) u_ex_stage (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_hold   (i_halt),
    .i_bubble (w_ex_bubble),
    .i_data   (w_ex_next),
    .i_valid  (i_valid),
    .o_data   (w_ex_q),
    .o_valid  (w_ex_valid)
  );

  assign w_mem_next = {w_ex_q[CTRL_REG_WRITE_BIT],
                       w_ex_q[CTRL_MEM_TO_REG_LSB +: CTRL_MEM_TO_REG_W],
                       w_ex_q[CTRL_MEM_WRITE_BIT]};

  ctrl_stage_reg #(
    .NB_DATA (NB_MEM_CTRL)
  ) u_mem_stage (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_hold   (i_halt),
    .i_bubble (1'b0),
    .i_data   (w_mem_next),
    .i_valid  (w_ex_valid),
    .o_data   (w_mem_q),
    .o_valid  (w_mem_valid)
  );

  ctrl_stage_reg #(
    .NB_DATA (NB_WB_CTRL)
  ) u_wb_stage (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_hold   (i_halt),
    .i_bubble (1'b0),
    .i_data   (w_mem_q[NB_MEM_CTRL-1:1]),
    .i_valid  (w_mem_valid),
    .o_data   (w_wb_q),
    .o_valid  (w_wb_valid)
  );

  assign o_ex_reg_write   = w_ex_q[CTRL_REG_WRITE_BIT];
  assign o_ex_reg_dst     = w_ex_q[CTRL_REG_DST_LSB +: CTRL_REG_DST_W];
  assign o_ex_mem_to_reg  = w_ex_q[CTRL_MEM_TO_REG_LSB +: CTRL_MEM_TO_REG_W];
  assign o_ex_mem_write   = w_ex_q[CTRL_MEM_WRITE_BIT];
  assign o_ex_alu_src     = w_ex_q[CTRL_ALU_SRC_LSB +: CTRL_ALU_SRC_W];
  assign o_ex_alu_op      = w_ex_q[CTRL_ALU_OP_LSB +: CTRL_ALU_OP_W];
  assign o_ex_mem_read    = w_ex_valid & o_ex_reg_write & (o_ex_mem_to_reg != MEM_TO_REG_ALU);

  assign o_mem_reg_write  = w_mem_q[3];
  assign o_mem_mem_to_reg = w_mem_q[2:1];
  assign o_mem_mem_write  = w_mem_q[0];

  assign o_wb_reg_write   = w_wb_q[2];
  assign o_wb_mem_to_reg  = w_wb_q[1:0];

  assign o_pipe_empty     = ~(w_ex_valid | w_mem_valid | w_wb_valid);

`ifdef CTRL_PIPE_STATS_EN
  logic [NB_STAT-1:0] r_stat_retired;
  logic [NB_STAT-1:0] r_stat_bubbles;
  logic [NB_STAT-1:0] r_stat_stores;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stat_retired <= '0;
      r_stat_bubbles <= '0;
      r_stat_stores  <= '0;
    end else if (!i_halt) begin
      if (w_wb_valid)                     r_stat_retired <= r_stat_retired + 1'b1;
      if (w_ex_bubble)                    r_stat_bubbles <= r_stat_bubbles + 1'b1;
      if (w_mem_valid && o_mem_mem_write) r_stat_stores  <= r_stat_stores + 1'b1;
    end
  end

  assign o_stat_retired = r_stat_retired;
  assign o_stat_bubbles = r_stat_bubbles;
  assign o_stat_stores  = r_stat_stores;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe; checks sampled 1 ns after posedge.
// Counter checks are included when CTRL_PIPE_STATS_EN is defined.
module tb_ctrl_pipe;

  localparam logic [13:0] ADDI = 14'h0408;
  localparam logic [13:0] LW   = 14'h0448;
  localparam logic [13:0] SW   = 14'h0328;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] ctrl;
  logic        valid, stall, flush, halt;
  logic        ex_reg_write, ex_mem_write, ex_mem_read;
  logic [1:0]  ex_reg_dst, ex_mem_to_reg, ex_alu_src;
  logic [2:0]  ex_alu_op;
  logic        mem_reg_write, mem_mem_write, wb_reg_write, pipe_empty;
  logic [1:0]  mem_mem_to_reg, wb_mem_to_reg;
`ifdef CTRL_PIPE_STATS_EN
  logic [31:0] stat_retired, stat_bubbles, stat_stores;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ctrl_pipe u_dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_ctrl_regs      (ctrl),
    .i_valid          (valid),
    .i_stall          (stall),
    .i_flush          (flush),
    .i_halt           (halt),
    .o_ex_reg_write   (ex_reg_write),
    .o_ex_reg_dst     (ex_reg_dst),
    .o_ex_mem_to_reg  (ex_mem_to_reg),
    .o_ex_mem_write   (ex_mem_write),
    .o_ex_alu_src     (ex_alu_src),
    .o_ex_alu_op      (ex_alu_op),
    .o_ex_mem_read    (ex_mem_read),
    .o_mem_reg_write  (mem_reg_write),
    .o_mem_mem_to_reg (mem_mem_to_reg),
    .o_mem_mem_write  (mem_mem_write),
    .o_wb_reg_write   (wb_reg_write),
    .o_wb_mem_to_reg  (wb_mem_to_reg),
`ifdef CTRL_PIPE_STATS_EN
    .o_stat_retired   (stat_retired),
    .o_stat_bubbles   (stat_bubbles),
    .o_stat_stores    (stat_stores),
`endif
    .o_pipe_empty     (pipe_empty)
  );

  // EX fields packed: rw, dst, m2r, mw, src, op, mem_read (12 bits)
  wire [11:0] ex_all = {ex_reg_write, ex_reg_dst, ex_mem_to_reg, ex_mem_write,
                        ex_alu_src, ex_alu_op, ex_mem_read};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [13:0] c, input logic v, input logic s,
                       input logic f, input logic h);
    ctrl = c; valid = v; stall = s; flush = f; halt = h;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(14'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (ex_all !== 12'h000) begin
      n_fail++; $display("FAIL reset_ex got=%h exp=000", ex_all);
    end
    n_checks++;
    if ({mem_reg_write, mem_mem_to_reg, mem_mem_write, wb_reg_write, wb_mem_to_reg} !== 7'h00) begin
      n_fail++; $display("FAIL reset_mem_wb got=%b exp=0000000",
                         {mem_reg_write, mem_mem_to_reg, mem_mem_write, wb_reg_write, wb_mem_to_reg});
    end
    n_checks++;
    if (pipe_empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_empty got=%b exp=1", pipe_empty);
    end
  endtask

  task automatic test_addi();
    do_reset();
    drive(ADDI, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(14'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({ex_reg_write, ex_alu_src, pipe_empty} !== 4'b1010) begin
      n_fail++; $display("FAIL addi_c1 got=%b exp=1010", {ex_reg_write, ex_alu_src, pipe_empty});
    end
    step();
    n_checks++;
    if ({ex_reg_write, mem_reg_write, pipe_empty} !== 3'b010) begin
      n_fail++; $display("FAIL addi_c2 got=%b exp=010", {ex_reg_write, mem_reg_write, pipe_empty});
    end
    step();
    n_checks++;
    if ({mem_reg_write, wb_reg_write, pipe_empty} !== 3'b010) begin
      n_fail++; $display("FAIL addi_c3 got=%b exp=010", {mem_reg_write, wb_reg_write, pipe_empty});
    end
    step();
    n_checks++;
    if ({wb_reg_write, pipe_empty} !== 2'b01) begin
      n_fail++; $display("FAIL addi_c4 got=%b exp=01", {wb_reg_write, pipe_empty});
    end
  endtask

  task automatic test_load_stall();
    do_reset();
    drive(LW, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++;
    if ({ex_mem_read, ex_mem_to_reg, ex_reg_write} !== 4'b1011) begin
      n_fail++; $display("FAIL lw_ex got=%b exp=1011", {ex_mem_read, ex_mem_to_reg, ex_reg_write});
    end
    // Stall discards whatever ID presents this cycle.
    drive(ADDI, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive(14'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ex_all !== 12'h000) begin
      n_fail++; $display("FAIL lw_stall_ex got=%h exp=000", ex_all);
    end
    n_checks++;
    if ({mem_reg_write, mem_mem_to_reg} !== 3'b101) begin
      n_fail++; $display("FAIL lw_stall_mem got=%b exp=101", {mem_reg_write, mem_mem_to_reg});
    end
    step();
    n_checks++;
    if ({wb_reg_write, wb_mem_to_reg, mem_reg_write} !== 4'b1010) begin
      n_fail++; $display("FAIL lw_wb got=%b exp=1010", {wb_reg_write, wb_mem_to_reg, mem_reg_write});
    end
  endtask

  task automatic test_store();
    do_reset();
    drive(SW, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(14'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    // rw=0 dst=00 m2r=00 mw=1 src=01 op=000 mem_read=0
    n_checks++;
    if (ex_all !== 12'b0_00_00_1_01_000_0) begin
      n_fail++; $display("FAIL sw_ex got=%b exp=000001010000", ex_all);
    end
    step();
    n_checks++;
    if ({mem_mem_write, mem_reg_write, mem_mem_to_reg} !== 4'b1000) begin
      n_fail++; $display("FAIL sw_mem got=%b exp=1000",
                         {mem_mem_write, mem_reg_write, mem_mem_to_reg});
    end
`ifdef CTRL_PIPE_STATS_EN
    n_checks++;
    if (stat_stores !== 32'd0) begin
      n_fail++; $display("FAIL sw_stat_before got=%0d exp=0", stat_stores);
    end
    step();
    n_checks++;
    if (stat_stores !== 32'd1) begin
      n_fail++; $display("FAIL sw_stat_after got=%0d exp=1", stat_stores);
    end
`endif
  endtask

  task automatic test_halt();
    do_reset();
    drive(14'h0409, 1'b1, 1'b0, 1'b0, 1'b0);  // A: op 001, m2r 00
    step();
    drive(14'h044A, 1'b1, 1'b0, 1'b0, 1'b0);  // B: op 010, m2r 01
    step();
    drive(14'h040B, 1'b1, 1'b0, 1'b0, 1'b1);  // C: op 011 waits during halt
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({ex_alu_op, ex_mem_to_reg, mem_reg_write, mem_mem_to_reg, wb_reg_write} !== 9'b010_01_1_00_0) begin
        n_fail++; $display("FAIL halt_frozen%0d got=%b exp=010011000", i,
                           {ex_alu_op, ex_mem_to_reg, mem_reg_write, mem_mem_to_reg, wb_reg_write});
      end
    end
    drive(14'h040B, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(14'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({ex_alu_op, mem_mem_to_reg, wb_reg_write, wb_mem_to_reg} !== 8'b011_01_1_00) begin
      n_fail++; $display("FAIL halt_resume1 got=%b exp=01101100",
                         {ex_alu_op, mem_mem_to_reg, wb_reg_write, wb_mem_to_reg});
    end
    step();
    n_checks++;
    if ({ex_alu_op, mem_reg_write, mem_mem_to_reg, wb_mem_to_reg} !== 8'b000_1_00_01) begin
      n_fail++; $display("FAIL halt_resume2 got=%b exp=00010001",
                         {ex_alu_op, mem_reg_write, mem_mem_to_reg, wb_mem_to_reg});
    end
    step();
    n_checks++;
    if ({mem_reg_write, wb_reg_write, wb_mem_to_reg, pipe_empty} !== 5'b0_1_00_0) begin
      n_fail++; $display("FAIL halt_resume3 got=%b exp=01000",
                         {mem_reg_write, wb_reg_write, wb_mem_to_reg, pipe_empty});
    end
    step();
    n_checks++;
    if (pipe_empty !== 1'b1) begin
      n_fail++; $display("FAIL halt_drain got=%b exp=1", pipe_empty);
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    drive(LW, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    n_checks++;
    if ({ex_all, pipe_empty} !== 13'h0001) begin
      n_fail++; $display("FAIL sf_bubble got=%h exp=0001", {ex_all, pipe_empty});
    end
    drive(LW, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(14'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ex_mem_read !== 1'b1) begin
      n_fail++; $display("FAIL sf_single got=%b exp=1", ex_mem_read);
    end
    step();
    n_checks++;
    if ({wb_reg_write, mem_reg_write} !== 2'b01) begin
      n_fail++; $display("FAIL sf_no_wb got=%b exp=01", {wb_reg_write, mem_reg_write});
    end
`ifdef CTRL_PIPE_STATS_EN
    n_checks++;
    if (stat_bubbles !== 32'd2) begin
      n_fail++; $display("FAIL sf_stat_bubbles got=%0d exp=2", stat_bubbles);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(ADDI, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    n_checks++;
    if ({ex_reg_write, mem_reg_write, wb_reg_write, pipe_empty} !== 4'b1110) begin
      n_fail++; $display("FAIL rm_full got=%b exp=1110",
                         {ex_reg_write, mem_reg_write, wb_reg_write, pipe_empty});
    end
    drive(ADDI, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(14'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({ex_all, mem_reg_write, mem_mem_to_reg, mem_mem_write, wb_reg_write, wb_mem_to_reg, pipe_empty}
        !== 20'h00001) begin
      n_fail++; $display("FAIL rm_cleared got=%h exp=00001",
                         {ex_all, mem_reg_write, mem_mem_to_reg, mem_mem_write, wb_reg_write,
                          wb_mem_to_reg, pipe_empty});
    end
`ifdef CTRL_PIPE_STATS_EN
    n_checks++;
    if ({stat_retired, stat_bubbles, stat_stores} !== 96'd0) begin
      n_fail++; $display("FAIL rm_stats got=%h/%h/%h exp=0", stat_retired, stat_bubbles, stat_stores);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    drive(14'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_addi();
    test_load_stall();
    test_store();
    test_halt();
    test_stall_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
